// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
//   Runs one player's turn, starting when the game FSM grants the turn and
//   ending when the turn-done report goes back. The steps are: arm, charge the
//   throw power while fire is held, launch, wait for the projectile result,
//   issue damage on a hit, then pulse turn_done_dog or turn_done_cat.
//
//   Optional feature (macro TURN_TIMEOUT_EN):
//     When defined, a turn timer runs in READY and CHARGE. After TURN_TMO
//     cycles it forces a throw with the current power (0 if still in READY).
//     When undefined, READY and CHARGE wait indefinitely.
//
// Ports
//   clk            in   1   system clock
//   rst            in   1   synchronous, active-high reset
//   turn_active    in   1   turn granted (game FSM next_turn level)
//   is_dog         in   1   turn owner, latched at turn start
//   fire_held      in   1   fire key level for the current owner
//   proj_done      in   1   projectile flight finished (1-cycle pulse)
//   proj_hit       in   1   projectile hit the opponent (qualified by proj_done)
//   power          out  7   current / launched throw power
//   throw_start    out  1   1-cycle launch pulse
//   throw_dog      out  1   latched owner (1 = dog throws)
//   dmg_valid      out  1   1-cycle damage pulse
//   dmg_to_cat     out  1   damage target (1 = cat)
//   dmg_amount     out  10  damage value, valid with dmg_valid (0 otherwise)
//   turn_done_dog  out  1   1-cycle pulse: dog turn complete
//   turn_done_cat  out  1   1-cycle pulse: cat turn complete
//   seq_state      out  3   current state encoding
// -----------------------------------------------------------------------------
module turn_sequencer #(
    parameter int POWER_MAX  = 100,
    parameter int POWER_DIV  = 650_000,
    parameter int FLIGHT_TMO = 130_000_000,
    parameter int DMG_BASE   = 10,
    parameter int TURN_TMO   = 650_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       turn_active,
    input  logic       is_dog,
    input  logic       fire_held,
    input  logic       proj_done,
    input  logic       proj_hit,
    output logic [6:0] power,
    output logic       throw_start,
    output logic       throw_dog,
    output logic       dmg_valid,
    output logic       dmg_to_cat,
    output logic [9:0] dmg_amount,
    output logic       turn_done_dog,
    output logic       turn_done_cat,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_READY  = 3'd2,
        S_CHARGE = 3'd3,
        S_THROW  = 3'd4,
        S_FLIGHT = 3'd5,
        S_DAMAGE = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] div_cnt;
    logic [31:0] flight_cnt;
    logic        done_sent;
    logic        turn_expired;
    logic        flight_expired;

    function automatic logic [6:0] power_step(input logic [6:0] p);
        return (int'(p) >= POWER_MAX) ? p : p + 7'd1;
    endfunction

    function automatic logic [9:0] dmg_calc(input logic [6:0] p);
        return 10'(DMG_BASE) + 10'(p >> 3);
    endfunction

    assign flight_expired = (flight_cnt == 32'(FLIGHT_TMO - 1));

`ifdef TURN_TIMEOUT_EN
    logic [31:0] turn_cnt;

    assign turn_expired = (turn_cnt == 32'(TURN_TMO - 1));

    // Counts only while waiting on the player; starts from 0 on every turn.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            turn_cnt <= '0;
        end else if (state == S_READY || state == S_CHARGE) begin
            turn_cnt <= turn_cnt + 32'd1;
        end
    end
`else
    // Timeout feature absent: folds to constant 0 for any meaningful TURN_TMO.
    assign turn_expired = (TURN_TMO < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            power      <= '0;
            throw_dog  <= 1'b0;
            div_cnt    <= '0;
            flight_cnt <= '0;
            done_sent  <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_sent  <= (state == S_DONE);
            flight_cnt <= (state == S_FLIGHT) ? flight_cnt + 32'd1 : '0;

            if (state == S_IDLE && state_nxt == S_ARM) begin
                throw_dog <= is_dog;
                power     <= '0;
            end

            if (state == S_READY) begin
                div_cnt <= '0;
            end

            // Every cycle spent in CHARGE counts, including the release
            // cycle, so a hold of N cycles from READY yields N/POWER_DIV steps.
            if (state == S_CHARGE) begin
                if (div_cnt == 32'(POWER_DIV - 1)) begin
                    div_cnt <= '0;
                    power   <= power_step(power);
                end else begin
                    div_cnt <= div_cnt + 32'd1;
                end
            end

            // Any return to IDLE (normal exit or abort) clears the power.
            if (state != S_IDLE && state_nxt == S_IDLE) begin
                power <= '0;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        throw_start   = 1'b0;
        dmg_valid     = 1'b0;
        turn_done_dog = 1'b0;
        turn_done_cat = 1'b0;

        case (state)
            S_IDLE: begin
                if (turn_active) state_nxt = S_ARM;
            end
            S_ARM: begin
                // A key still held from the previous turn must be released first.
                if (!turn_active)    state_nxt = S_IDLE;
                else if (!fire_held) state_nxt = S_READY;
            end
            S_READY: begin
                if (!turn_active)      state_nxt = S_IDLE;
                else if (turn_expired) state_nxt = S_THROW;
                else if (fire_held)    state_nxt = S_CHARGE;
            end
            S_CHARGE: begin
                if (!turn_active)                    state_nxt = S_IDLE;
                else if (!fire_held || turn_expired) state_nxt = S_THROW;
            end
            S_THROW: begin
                if (!turn_active) begin
                    state_nxt = S_IDLE;
                end else begin
                    throw_start = 1'b1;
                    state_nxt   = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (!turn_active)        state_nxt = S_IDLE;
                else if (proj_done)      state_nxt = proj_hit ? S_DAMAGE : S_DONE;
                else if (flight_expired) state_nxt = S_DONE;
            end
            S_DAMAGE: begin
                if (!turn_active) begin
                    state_nxt = S_IDLE;
                end else begin
                    dmg_valid = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Report once on entry, then idle here until the grant drops.
                if (!done_sent) begin
                    turn_done_dog = throw_dog;
                    turn_done_cat = !throw_dog;
                end
                if (!turn_active) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dmg_to_cat = throw_dog;
    assign dmg_amount = dmg_valid ? dmg_calc(power) : 10'd0;
    assign seq_state  = state;

endmodule

// File: tb/tb_turn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_turn_sequencer
//   Self-checking bench for turn_sequencer with POWER_DIV=4, FLIGHT_TMO=50,
//   TURN_TMO=200. A cycle-by-cycle vector table covers one short dog turn.
//   Hand-written sequences cover charging, saturation, key held over from an
//   earlier turn, flight timeout, aborts, reset mid-turn and the optional turn
//   timeout (TURN_TIMEOUT_EN).
//   Inputs change on the falling edge. Outputs are sampled shortly after it.
// -----------------------------------------------------------------------------
module tb_turn_sequencer;

    localparam int POWER_DIV  = 4;
    localparam int FLIGHT_TMO = 50;
    localparam int TURN_TMO   = 200;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_READY  = 3'd2;
    localparam logic [2:0] ST_CHARGE = 3'd3;
    localparam logic [2:0] ST_FLIGHT = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd7;

`ifdef TURN_TIMEOUT_EN
    // The turn timer forces the throw after 199 CHARGE cycles: 49 power steps.
    localparam logic [6:0] EXP_POWER_LONG = 7'd49;
`else
    localparam logic [6:0] EXP_POWER_LONG = 7'd100;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       turn_active = 1'b0;
    logic       is_dog = 1'b0;
    logic       fire_held = 1'b0;
    logic       proj_done = 1'b0;
    logic       proj_hit = 1'b0;
    logic [6:0] power;
    logic       throw_start;
    logic       throw_dog;
    logic       dmg_valid;
    logic       dmg_to_cat;
    logic [9:0] dmg_amount;
    logic       turn_done_dog;
    logic       turn_done_cat;
    logic [2:0] seq_state;

    always #5 clk = ~clk;

    turn_sequencer #(
        .POWER_MAX (100),
        .POWER_DIV (POWER_DIV),
        .FLIGHT_TMO(FLIGHT_TMO),
        .DMG_BASE  (10),
        .TURN_TMO  (TURN_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .turn_active  (turn_active),
        .is_dog       (is_dog),
        .fire_held    (fire_held),
        .proj_done    (proj_done),
        .proj_hit     (proj_hit),
        .power        (power),
        .throw_start  (throw_start),
        .throw_dog    (throw_dog),
        .dmg_valid    (dmg_valid),
        .dmg_to_cat   (dmg_to_cat),
        .dmg_amount   (dmg_amount),
        .turn_done_dog(turn_done_dog),
        .turn_done_cat(turn_done_cat),
        .seq_state    (seq_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Pulse counters and values captured alongside each pulse.
    int         n_throw = 0;
    int         n_dmg   = 0;
    int         n_dd    = 0;
    int         n_dc    = 0;
    logic [6:0] thr_pw    = 7'd0;
    logic [9:0] last_amt  = 10'd0;
    logic       last_cat  = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (throw_start) begin
                n_throw++;
                thr_pw = power;
            end
            if (dmg_valid) begin
                n_dmg++;
                last_amt = dmg_amount;
                last_cat = dmg_to_cat;
            end
            if (turn_done_dog) n_dd++;
            if (turn_done_cat) n_dc++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (seq_state == st) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Grants a turn and returns once the sequencer sits in READY.
    task automatic start_turn(input logic dog, input string name);
        @(negedge clk);
        turn_active = 1'b1;
        is_dog      = dog;
        fire_held   = 1'b0;
        proj_done   = 1'b0;
        proj_hit    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check(name, 32'(seq_state), 32'(ST_READY));
    endtask

    task automatic hold_fire(input int n);
        fire_held = 1'b1;
        repeat (n) @(negedge clk);
        fire_held = 1'b0;
    endtask

    task automatic end_turn(input string name);
        @(negedge clk);
        turn_active = 1'b0;
        fire_held   = 1'b0;
        @(negedge clk);
        #1;
        check(name, {22'd0, seq_state, power}, {22'd0, ST_IDLE, 7'd0});
    endtask

    typedef struct {
        logic       ta, dog, fire, pd, ph;
        logic [2:0] st;
        logic       ts, dv, tdd, tdc;
        logic [6:0] pw;
        logic [9:0] amt;
    } vec_t;

    vec_t vecs[17];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int t0, d0, dd0, dc0, k;

        // Inputs {ta,dog,fire,pd,ph}; expected {state,throw,dmg,done_dog,done_cat,power,amount}
        // as seen before the next rising edge.
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd1, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd2, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd3, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd3, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd3, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd3, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd3, 1'b0,1'b0,1'b0,1'b0, 7'd1, 10'd0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd4, 1'b1,1'b0,1'b0,1'b0, 7'd1, 10'd0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd5, 1'b0,1'b0,1'b0,1'b0, 7'd1, 10'd0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 3'd5, 1'b0,1'b0,1'b0,1'b0, 7'd1, 10'd0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd6, 1'b0,1'b1,1'b0,1'b0, 7'd1, 10'd10};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd7, 1'b0,1'b0,1'b1,1'b0, 7'd1, 10'd0};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd7, 1'b0,1'b0,1'b0,1'b0, 7'd1, 10'd0};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd7, 1'b0,1'b0,1'b0,1'b0, 7'd1, 10'd0};
        vecs[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0, 7'd0, 10'd0};

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {10'd0, seq_state, throw_start, throw_dog, dmg_valid, dmg_to_cat,
               turn_done_dog, turn_done_cat, power, dmg_amount},
              32'd0);
        rst = 1'b0;

        // Short dog turn, cycle by cycle.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            turn_active = vecs[i].ta;
            is_dog      = vecs[i].dog;
            fire_held   = vecs[i].fire;
            proj_done   = vecs[i].pd;
            proj_hit    = vecs[i].ph;
            #1;
            check($sformatf("vec%0d", i),
                  32'({seq_state, throw_start, dmg_valid, turn_done_dog, turn_done_cat, power, dmg_amount}),
                  32'({vecs[i].st, vecs[i].ts, vecs[i].dv, vecs[i].tdd, vecs[i].tdc, vecs[i].pw, vecs[i].amt}));
        end
        proj_done = 1'b0;
        proj_hit  = 1'b0;

        // Dog, fire held 40 cycles, hit: power 10, damage 10 + 10/8 = 11.
        t0 = n_throw; d0 = n_dmg; dd0 = n_dd; dc0 = n_dc;
        start_turn(1'b1, "t1_ready");
        hold_fire(40);
        wait_state(ST_FLIGHT, 10, "t1_flight");
        proj_done = 1'b1;
        proj_hit  = 1'b1;
        @(negedge clk);
        proj_done = 1'b0;
        proj_hit  = 1'b0;
        wait_state(ST_DONE, 10, "t1_done");
        repeat (5) @(negedge clk);
        check("t1_throws",   32'(n_throw - t0), 32'd1);
        check("t1_power",    32'(thr_pw),       32'd10);
        check("t1_dmg_cnt",  32'(n_dmg - d0),   32'd1);
        check("t1_dmg_amt",  32'(last_amt),     32'd11);
        check("t1_dmg_cat",  32'(last_cat),     32'd1);
        check("t1_done_dog", 32'(n_dd - dd0),   32'd1);
        check("t1_done_cat", 32'(n_dc - dc0),   32'd0);
        end_turn("t1_idle");

        // Cat, long hold: power saturates; miss gives no damage.
        t0 = n_throw; d0 = n_dmg; dd0 = n_dd; dc0 = n_dc;
        start_turn(1'b0, "t2_ready");
        fire_held = 1'b1;
        for (int i = 0; i < 1000 && n_throw == t0; i++) @(negedge clk);
        fire_held = 1'b0;
        wait_state(ST_FLIGHT, 10, "t2_flight");
        proj_done = 1'b1;
        proj_hit  = 1'b0;
        @(negedge clk);
        proj_done = 1'b0;
        wait_state(ST_DONE, 10, "t2_done");
        repeat (5) @(negedge clk);
        check("t2_throws",   32'(n_throw - t0), 32'd1);
        check("t2_power",    32'(thr_pw),       32'(EXP_POWER_LONG));
        check("t2_dmg_cnt",  32'(n_dmg - d0),   32'd0);
        check("t2_done_cat", 32'(n_dc - dc0),   32'd1);
        check("t2_done_dog", 32'(n_dd - dd0),   32'd0);
        end_turn("t2_idle");

        // Fire held over from before the turn: stays in ARM until released.
        // Then no proj_done at all: DONE after FLIGHT_TMO cycles in FLIGHT.
        t0 = n_throw; d0 = n_dmg; dd0 = n_dd; dc0 = n_dc;
        @(negedge clk);
        turn_active = 1'b1;
        is_dog      = 1'b1;
        fire_held   = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t3_arm_hold", {22'd0, seq_state, power}, {22'd0, ST_ARM, 7'd0});
        fire_held = 1'b0;
        @(negedge clk);
        #1;
        check("t3_ready", 32'(seq_state), 32'(ST_READY));
        hold_fire(8);
        wait_state(ST_FLIGHT, 10, "t4_flight");
        k = 0;
        while (seq_state != ST_DONE && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t4_flight_cycles", 32'(k), 32'(FLIGHT_TMO));
        repeat (3) @(negedge clk);
        check("t4_throws",   32'(n_throw - t0), 32'd1);
        check("t4_power",    32'(thr_pw),       32'd2);
        check("t4_dmg_cnt",  32'(n_dmg - d0),   32'd0);
        check("t4_done_dog", 32'(n_dd - dd0),   32'd1);
        end_turn("t4_idle");

        // proj_done outside FLIGHT is ignored, then abort while charging.
        t0 = n_throw; d0 = n_dmg;
        start_turn(1'b1, "t5a_ready");
        proj_done = 1'b1;
        proj_hit  = 1'b1;
        @(negedge clk);
        proj_done = 1'b0;
        proj_hit  = 1'b0;
        #1;
        check("t5a_pd_ignored", 32'(seq_state), 32'(ST_READY));
        fire_held = 1'b1;
        repeat (10) @(negedge clk);
        turn_active = 1'b0;
        fire_held   = 1'b0;
        @(negedge clk);
        #1;
        check("t5a_abort", {22'd0, seq_state, power}, {22'd0, ST_IDLE, 7'd0});
        check("t5a_throws", 32'(n_throw - t0), 32'd0);
        check("t5a_dmg_cnt", 32'(n_dmg - d0), 32'd0);

        // Abort in the same cycle as a hit report.
        t0 = n_throw; d0 = n_dmg; dd0 = n_dd; dc0 = n_dc;
        start_turn(1'b0, "t5b_ready");
        hold_fire(4);
        wait_state(ST_FLIGHT, 10, "t5b_flight");
        turn_active = 1'b0;
        proj_done   = 1'b1;
        proj_hit    = 1'b1;
        @(negedge clk);
        proj_done = 1'b0;
        proj_hit  = 1'b0;
        #1;
        check("t5b_abort", 32'(seq_state), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        check("t5b_throws",  32'(n_throw - t0), 32'd1);
        check("t5b_dmg_cnt", 32'(n_dmg - d0),   32'd0);
        check("t5b_done",    32'((n_dd - dd0) + (n_dc - dc0)), 32'd0);

        // Reset mid-charge returns everything to reset values.
        start_turn(1'b1, "t7_ready");
        fire_held = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t7_charging", {22'd0, seq_state, power}, {22'd0, ST_CHARGE, 7'd2});
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t7_reset", {21'd0, seq_state, throw_dog, power}, 32'd0);
        rst         = 1'b0;
        turn_active = 1'b0;
        fire_held   = 1'b0;
        @(negedge clk);

        // Turn timeout: fire never pressed.
        t0 = n_throw;
`ifdef TURN_TIMEOUT_EN
        @(negedge clk);
        turn_active = 1'b1;
        is_dog      = 1'b1;
        k = 0;
        while (!throw_start && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        // One cycle each in IDLE and ARM, then TURN_TMO cycles in READY.
        check("t6_timeout_cycles", 32'(k), 32'(2 + TURN_TMO));
        check("t6_timeout_power",  32'(power), 32'd0);
        wait_state(ST_DONE, 100, "t6_done");
        end_turn("t6_idle");
        check("t6_throws", 32'(n_throw - t0), 32'd1);
`else
        start_turn(1'b1, "t6_ready");
        repeat (1000) @(negedge clk);
        #1;
        check("t6_still_ready", 32'(seq_state), 32'(ST_READY));
        check("t6_no_throw",    32'(n_throw - t0), 32'd0);
        end_turn("t6_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
